// File: rtl/multisim_client_push_buffered_if.sv
// -----------------------------------------------------------------------------
// multisim_client_push_buffered_if
//   Valid/ready word interface between the local design (master) and the
//   multisim push client (slave), plus the server-call boundary used by the
//   client.
//
//   Interface signals:
//     data_vld  master -> slave  design offers a word
//     data_rdy  slave  -> master client can take a word this cycle
//     data      master -> slave  payload, sampled when data_vld && data_rdy
//
//   Server-call boundary (compilation-unit scope):
//     an in-language loopback server providing multisim_client_start and
//     multisim_client_push_packed. It logs every push and answers according
//     to a policy.
// -----------------------------------------------------------------------------

localparam int MULTISIM_MAX_DATA_WIDTH = 32'sd1024;

// One logged push attempt as seen by the loopback server.
typedef struct {
  bit [MULTISIM_MAX_DATA_WIDTH-1:0] data;
  int                               ret;
  int                               data_width;
  string                            server_name;
} multisim_sv_call_t;

// Answer policy: 0 accept all, 1 refuse all,
// 2 refuse pushes of multisim_sv_refuse_word while refusals < refuse_limit.
int                               multisim_sv_policy       = 32'sd0;
bit [MULTISIM_MAX_DATA_WIDTH-1:0] multisim_sv_refuse_word  = '0;
int                               multisim_sv_refuse_limit = 32'sd0;
int                               multisim_sv_refusals     = 32'sd0;
int                               multisim_sv_start_calls  = 32'sd0;
multisim_sv_call_t                multisim_sv_call_log[$];

function automatic void multisim_client_start(
  input string server_runtime_directory,
  input string server_name
);
  if ((server_runtime_directory.len() + server_name.len()) >= 32'sd0) begin
    multisim_sv_start_calls = multisim_sv_start_calls + 32'sd1;
  end else begin
    multisim_sv_start_calls = multisim_sv_start_calls;
  end
endfunction

function automatic int multisim_client_push_packed(
  input string                              server_name,
  input bit [MULTISIM_MAX_DATA_WIDTH-1:0]   data,
  input int                                 data_width
);
  multisim_sv_call_t entry;
  int                ret;
  case (multisim_sv_policy)
    32'sd0:  ret = 32'sd1;
    32'sd1:  ret = 32'sd0;
    32'sd2:  ret = ((data == multisim_sv_refuse_word) &&
                    (multisim_sv_refusals < multisim_sv_refuse_limit)) ? 32'sd0 : 32'sd1;
    default: ret = 32'sd1;
  endcase
  if (ret == 32'sd0) begin
    multisim_sv_refusals = multisim_sv_refusals + 32'sd1;
  end else begin
    multisim_sv_refusals = multisim_sv_refusals;
  end
  entry.data        = data;
  entry.ret         = ret;
  entry.data_width  = data_width;
  entry.server_name = server_name;
  multisim_sv_call_log.push_back(entry);
  return ret;
endfunction

interface multisim_client_push_buffered_if #(
  parameter int DATA_WIDTH = 32'sd64
);
  logic                  data_vld;
  logic                  data_rdy;
  logic [DATA_WIDTH-1:0] data;

  modport master (output data_vld, output data, input data_rdy);
  modport slave  (input data_vld, input data, output data_rdy);
endinterface

// File: rtl/multisim_client_push_buffered.sv
// -----------------------------------------------------------------------------
// multisim_client_push_buffered
//   Producer-end client of a multisim channel. Words offered by the local
//   design are buffered in a small FIFO and pushed to the named server, one
//   push call per cycle while the server accepts. When the server refuses a
//   word, the word stays at the head and the client waits RETRY_INTERVAL
//   cycles before retrying, which limits the call rate during backpressure.
//
//   Ports:
//     clk          clock, all logic on posedge
//     rst          synchronous active-high reset (discards buffered words)
//     server_name  channel/server identifier for every server call
//     bus          slave side of multisim_client_push_buffered_if
//                  (data_vld, data_rdy, data)
//
//   Parameters: SERVER_RUNTIME_DIRECTORY, DATA_WIDTH (<= 1024),
//               FIFO_DEPTH (power of two, >= 2), RETRY_INTERVAL (>= 1).
//
//   Optional build macro MULTISIM_CLIENT_PUSH_STATS_EN adds 64-bit counters
//   (push_ok, push_refused, max_occupancy, stall_cycles) cleared by rst and
//   printed at end of simulation. Functional behaviour is identical either way.
// -----------------------------------------------------------------------------

module multisim_client_push_buffered #(
  parameter string SERVER_RUNTIME_DIRECTORY = "../output_top",
  parameter int    DATA_WIDTH               = 32'sd64,
  parameter int    FIFO_DEPTH               = 32'sd4,
  parameter int    RETRY_INTERVAL           = 32'sd8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  string                                 server_name,
  multisim_client_push_buffered_if.slave        bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 32'sd1;
  localparam int BO_W  = (RETRY_INTERVAL > 32'sd1) ? $clog2(RETRY_INTERVAL) : 32'sd1;
  localparam logic [BO_W-1:0]  BO_LOAD   = BO_W'(RETRY_INTERVAL - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_ACTIVE  = 1'b0,
    ST_BACKOFF = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0]              fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0]                   wr_ptr_r;
  logic [PTR_W-1:0]                   rd_ptr_r;
  logic [CNT_W-1:0]                   count_r;
  logic [BO_W-1:0]                    backoff_r;
  state_t                             state_r;
  logic                               accept_s;
  logic [CNT_W-1:0]                   accept_inc_s;
  bit   [MULTISIM_MAX_DATA_WIDTH-1:0] push_word_s;

  // The server connection is opened once per simulation, not on reset.
  initial begin
    multisim_client_start(SERVER_RUNTIME_DIRECTORY, server_name);
  end

  // Ready depends only on registered occupancy and reset, never on data_vld.
  assign bus.data_rdy = !rst && (count_r != CNT_FULL);
  assign accept_s     = bus.data_vld && bus.data_rdy;
  assign accept_inc_s = {{(CNT_W - 1){1'b0}}, accept_s};

  // Zero-extend the FIFO head to the fixed width of the push call.
  always_comb begin
    push_word_s                 = '0;
    push_word_s[DATA_WIDTH-1:0] = fifo_r[rd_ptr_r];
  end

  // FIFO write side, push/retry state machine and occupancy bookkeeping.
  // The push call happens here so that it is issued exactly once per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      backoff_r <= '0;
      state_r   <= ST_ACTIVE;
    end else begin
      if (accept_s) begin
        fifo_r[wr_ptr_r] <= bus.data;
        wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r         <= wr_ptr_r;
      end

      case (state_r)
        ST_ACTIVE: begin
          if (count_r != '0) begin
            if ((multisim_client_push_packed(server_name, push_word_s, DATA_WIDTH)
                 & 32'sd1) != 32'sd0) begin
              rd_ptr_r <= rd_ptr_r + PTR_W'(1);
              count_r  <= count_r + accept_inc_s - CNT_W'(1);
            end else begin
              // Head word stays put; a one-cycle interval needs no backoff
              // state because the retry lands on the very next edge.
              count_r   <= count_r + accept_inc_s;
              backoff_r <= BO_LOAD;
              state_r   <= (BO_LOAD == '0) ? ST_ACTIVE : ST_BACKOFF;
            end
          end else begin
            count_r <= count_r + accept_inc_s;
          end
        end
        ST_BACKOFF: begin
          count_r <= count_r + accept_inc_s;
          // Leaving on the edge where the counter would reach zero puts the
          // retry exactly RETRY_INTERVAL edges after the refusal.
          if (backoff_r <= BO_W'(1)) begin
            backoff_r <= '0;
            state_r   <= ST_ACTIVE;
          end else begin
            backoff_r <= backoff_r - BO_W'(1);
          end
        end
        default: begin
          count_r   <= count_r + accept_inc_s;
          backoff_r <= '0;
          state_r   <= ST_ACTIVE;
        end
      endcase
    end
  end

`ifdef MULTISIM_CLIENT_PUSH_STATS_EN
  logic [63:0] push_ok_r;
  logic [63:0] push_refused_r;
  logic [63:0] max_occupancy_r;
  logic [63:0] stall_cycles_r;
  logic        push_call_s;

  assign push_call_s = !rst && (state_r == ST_ACTIVE) && (count_r != '0);

  // Outcome of each push is visible one edge later as a head-pointer move:
  // a call with no rd_ptr advance and a move into backoff (or retry) was
  // refused. Track it by watching rd_ptr across the call edge.
  logic [PTR_W-1:0] rd_ptr_prev_r;
  logic             call_prev_r;

  // Statistics counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_ok_r       <= 64'd0;
      push_refused_r  <= 64'd0;
      max_occupancy_r <= 64'd0;
      stall_cycles_r  <= 64'd0;
      rd_ptr_prev_r   <= '0;
      call_prev_r     <= 1'b0;
    end else begin
      rd_ptr_prev_r <= rd_ptr_r;
      call_prev_r   <= push_call_s;
      if (call_prev_r && (rd_ptr_r != rd_ptr_prev_r)) begin
        push_ok_r <= push_ok_r + 64'd1;
      end else if (call_prev_r) begin
        push_refused_r <= push_refused_r + 64'd1;
      end else begin
        push_ok_r <= push_ok_r;
      end
      if (64'(count_r) > max_occupancy_r) begin
        max_occupancy_r <= 64'(count_r);
      end else begin
        max_occupancy_r <= max_occupancy_r;
      end
      if (bus.data_vld && !bus.data_rdy) begin
        stall_cycles_r <= stall_cycles_r + 64'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

  final begin
    $display("multisim_client_push_buffered %s: push_ok=%0d push_refused=%0d max_occupancy=%0d stall_cycles=%0d",
             server_name, push_ok_r, push_refused_r, max_occupancy_r, stall_cycles_r);
  end
`endif

endmodule

// File: tb/tb_multisim_client_push_buffered.sv
module tb_multisim_client_push_buffered;

  localparam int DW = 64;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  string server_name_a = "chan_a";
  string server_name_b = "chan_b";
  int    sel = 0;          // 0: dut_a (RETRY_INTERVAL 8), 1: dut_b (RETRY_INTERVAL 1)
  int    checks = 0;
  int    errors = 0;

  multisim_client_push_buffered_if #(.DATA_WIDTH(DW)) bus_a ();
  multisim_client_push_buffered_if #(.DATA_WIDTH(DW)) bus_b ();

  multisim_client_push_buffered #(
    .SERVER_RUNTIME_DIRECTORY("../output_top"), .DATA_WIDTH(DW),
    .FIFO_DEPTH(4), .RETRY_INTERVAL(8)
  ) dut_a (.clk(clk), .rst(rst), .server_name(server_name_a), .bus(bus_a));

  multisim_client_push_buffered #(
    .SERVER_RUNTIME_DIRECTORY("../output_top"), .DATA_WIDTH(DW),
    .FIFO_DEPTH(4), .RETRY_INTERVAL(1)
  ) dut_b (.clk(clk), .rst(rst), .server_name(server_name_b), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Words the client holds, in order; the earliest cycle a push is allowed.
  logic [63:0] exp_q[$];
  int          next_ok  = 0;
  int          cyc      = 0;
  int          log_idx  = 0;
  int          max_occ  = 0;

  initial begin
    logic        s_rst, s_vld, acc, call_exp;
    logic [63:0] s_data;
    int          ri, n_new, occ;
    forever begin
      @(posedge clk);
      s_rst  = rst;
      s_vld  = (sel == 0) ? bus_a.data_vld : bus_b.data_vld;
      s_data = (sel == 0) ? bus_a.data : bus_b.data;
      ri     = (sel == 0) ? 8 : 1;
      #1;
      cyc++;
      n_new = multisim_sv_call_log.size() - log_idx;
      if (s_rst) begin
        chk("no_call_in_rst", 64'(n_new), 64'd0);
        exp_q.delete();
        next_ok = 0;
      end else begin
        occ      = exp_q.size();
        acc      = s_vld && (occ != 4);
        call_exp = (occ > 0) && (cyc >= next_ok);
        chk("call_count", 64'(n_new), call_exp ? 64'd1 : 64'd0);
        if (call_exp && n_new >= 1) begin
          chk("call_data", multisim_sv_call_log[log_idx].data[63:0], exp_q[0]);
          if ((multisim_sv_call_log[log_idx].ret & 1) != 0) void'(exp_q.pop_front());
          else next_ok = cyc + ri;
        end
        if (acc) exp_q.push_back(s_data);
        if (exp_q.size() > max_occ) max_occ = exp_q.size();
      end
      log_idx += n_new;
      @(negedge clk);
      chk("data_rdy", (sel == 0) ? 64'(bus_a.data_rdy) : 64'(bus_b.data_rdy),
          (!rst && exp_q.size() != 4) ? 64'd1 : 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [63:0] d);
    if (sel == 0) begin bus_a.data_vld = v; bus_a.data = d; end
    else          begin bus_b.data_vld = v; bus_b.data = d; end
  endtask

  task automatic send_words(input logic [63:0] first, input int n, input int budget);
    int   i = 0;
    int   t = 0;
    logic took;
    @(posedge clk); #2;
    drive(1'b1, first);
    while (i < n && t < budget) begin
      @(negedge clk);
      took = (sel == 0) ? bus_a.data_rdy : bus_b.data_rdy;
      @(posedge clk); #2;
      t++;
      if (took) begin
        i++;
        drive(1'b1, first + 64'(i));
      end
    end
    drive(1'b0, 64'd0);
    chk("send_done", 64'(i), 64'(n));
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic int ok_count(input int from);
    int n = 0;
    for (int i = from; i < multisim_sv_call_log.size(); i++)
      if ((multisim_sv_call_log[i].ret & 1) != 0) n++;
    return n;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int          base, base2, k, refused;
    logic [63:0] ok_words[$];
    logic [63:0] exp_seq[5];
    int          exp_ret[5];

    bus_a.data_vld = 1'b0; bus_a.data = 64'd0;
    bus_b.data_vld = 1'b0; bus_b.data = 64'd0;
    multisim_sv_policy = 0;

    // Reset
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst_a", 64'(bus_a.data_rdy), 64'd1);
    chk("rdy_after_rst_b", 64'(bus_b.data_rdy), 64'd1);
    chk("start_calls", 64'(multisim_sv_start_calls), 64'd2);

    // 1: server accepts everything, 0x1..0x10 streamed back to back
    base = multisim_sv_call_log.size();
    send_words(64'h1, 16, 100);
    wait_drain(20);
    chk("s1_calls", 64'(multisim_sv_call_log.size() - base), 64'd16);
    for (int i = 0; i < 16; i++)
      chk("s1_order", multisim_sv_call_log[base + i].data[63:0], 64'(i + 1));

    // 2: refuse all, six words, then accept
    multisim_sv_policy = 1;
    base = multisim_sv_call_log.size();
    fork
      send_words(64'h1, 6, 300);
      begin repeat (40) @(posedge clk); #3 multisim_sv_policy = 0; end
    join
    wait_drain(100);
    ok_words.delete();
    refused = 0;
    for (int i = base; i < multisim_sv_call_log.size(); i++) begin
      if ((multisim_sv_call_log[i].ret & 1) != 0) ok_words.push_back(multisim_sv_call_log[i].data[63:0]);
      else refused++;
    end
    chk("s2_ok_count", 64'(ok_words.size()), 64'd6);
    for (int i = 0; i < 6 && i < ok_words.size(); i++)
      chk("s2_order", ok_words[i], 64'(i + 1));
    chk("s2_refused_ge4", (refused >= 4) ? 64'd1 : 64'd0, 64'd1);
    chk("s2_max_occ", 64'(max_occ), 64'd4);

    // 3: RETRY_INTERVAL 1, one refusal of 0xA5
    sel = 1;
    multisim_sv_refuse_word  = '0;
    multisim_sv_refuse_word[63:0] = 64'hA5;
    multisim_sv_refuse_limit = multisim_sv_refusals + 1;
    multisim_sv_policy       = 2;
    base = multisim_sv_call_log.size();
    send_words(64'hA4, 4, 50);
    wait_drain(20);
    exp_seq = '{64'hA4, 64'hA5, 64'hA5, 64'hA6, 64'hA7};
    exp_ret = '{1, 0, 1, 1, 1};
    chk("s3_calls", 64'(multisim_sv_call_log.size() - base), 64'd5);
    for (int i = 0; i < 5 && base + i < multisim_sv_call_log.size(); i++) begin
      chk("s3_data", multisim_sv_call_log[base + i].data[63:0], exp_seq[i]);
      chk("s3_ret", 64'(multisim_sv_call_log[base + i].ret & 1), 64'(exp_ret[i]));
    end

    // 4: reset in BACKOFF with three buffered words
    sel = 0;
    multisim_sv_policy = 1;
    base = multisim_sv_call_log.size();
    send_words(64'h61, 3, 20);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("s4_rdy_in_rst", 64'(bus_a.data_rdy), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    multisim_sv_policy = 0;
    repeat (2) @(posedge clk);
    base2 = multisim_sv_call_log.size();
    send_words(64'h77, 1, 10);
    repeat (4) @(posedge clk);
    chk("s4_old_never_ok", 64'(ok_count(base) - ok_count(base2)), 64'd0);
    chk("s4_post_calls", 64'(multisim_sv_call_log.size() - base2), 64'd1);
    k = (base2 < multisim_sv_call_log.size()) ? base2 : 0;
    chk("s4_first_word", multisim_sv_call_log[k].data[63:0], 64'h77);
    chk("start_calls_end", 64'(multisim_sv_start_calls), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
